// File: rtl/l1d_pkg.sv
// Shared types and default geometry for the L1 data cache.
// Derived field widths follow from the default line/word geometry below.
package l1d_pkg;

    localparam int L1D_ADDR_WIDTH = 32;
    localparam int L1D_DATA_WIDTH = 32;
    localparam int L1D_NUM_LINES  = 64;
    localparam int L1D_LINE_WORDS = 4;

    localparam int OFF_BITS = $clog2(L1D_LINE_WORDS);
    localparam int IDX_BITS = $clog2(L1D_NUM_LINES);
    localparam int TAG_BITS = L1D_ADDR_WIDTH - IDX_BITS - OFF_BITS;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REFILL     = 2'd1,
        ST_WRITE_THRU = 2'd2,
        ST_RESPOND    = 2'd3
    } l1d_state_t;

    typedef struct packed {
        logic [L1D_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [L1D_DATA_WIDTH-1:0] wdata;
    } l1d_req_t;

endpackage

// File: rtl/l1d_line_store.sv
// Valid bits, tags and data words of the direct-mapped L1D.
// Reads are combinational by index; writes land on the clock edge.
module l1d_line_store
    import l1d_pkg::*;
#(
    parameter int DATA_WIDTH = L1D_DATA_WIDTH,
    parameter int NUM_LINES  = L1D_NUM_LINES,
    parameter int LINE_WORDS = L1D_LINE_WORDS,
    parameter int TAG_W      = TAG_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [DATA_WIDTH-1:0]         rd_word,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          tag_we,
    input  logic [$clog2(NUM_LINES)-1:0]  tag_idx,
    input  logic [TAG_W-1:0]              tag_wdata,
    input  logic                          valid_wdata,
    input  logic                          clr_all
);

    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES*LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[{rd_idx, rd_off}];

    // clear-all wins over a same-cycle tag write
    always_comb begin
        valid_d = valid_q;
        if (tag_we)
            valid_d[tag_idx] = valid_wdata;
        if (clr_all)
            valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (tag_we)
            tag_q[tag_idx] <= tag_wdata;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[{wr_idx, wr_off}] <= wr_data;
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-through L1 data cache; optional write-allocate on
// store miss is enabled by defining L1D_WRITE_ALLOCATE_EN.
module l1_dcache
    import l1d_pkg::*;
#(
    parameter int ADDR_WIDTH = L1D_ADDR_WIDTH,
    parameter int DATA_WIDTH = L1D_DATA_WIDTH,
    parameter int NUM_LINES  = L1D_NUM_LINES,
    parameter int LINE_WORDS = L1D_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inv_all,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic                  cpu_req_we,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic                  l2_req_valid,
    output logic [ADDR_WIDTH-1:0] l2_req_addr,
    output logic                  l2_req_we,
    output logic [DATA_WIDTH-1:0] l2_req_wdata,
    input  logic                  l2_rsp_valid,
    input  logic [DATA_WIDTH-1:0] l2_rsp_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    l1d_state_t            state_q, state_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    l1d_req_t              req_q, req_d;
    logic                  inv_pend_q, inv_pend_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  l2_valid_q, l2_valid_d;
    logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
    logic                  l2_we_q, l2_we_d;
    logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;

    logic [ADDR_WIDTH-1:0] look_addr;
    logic [IDX_W-1:0]      look_idx, req_idx, wr_idx;
    logic [OFF_W-1:0]      look_off, req_off, wr_off;
    logic [TAG_W-1:0]      look_tag, req_tag, line_tag;
    logic                  line_valid, hit, accept;
    logic [DATA_WIDTH-1:0] line_word, wr_data;
    logic                  wr_en, tag_we, valid_wdata, clr_all;

    // lookups follow the live CPU address in IDLE, the latched one otherwise
    assign look_addr = (state_q == ST_IDLE) ? cpu_req_addr : req_q.addr;
    assign look_off  = look_addr[OFF_W-1:0];
    assign look_idx  = look_addr[OFF_W +: IDX_W];
    assign look_tag  = look_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_off   = req_q.addr[OFF_W-1:0];
    assign req_idx   = req_q.addr[OFF_W +: IDX_W];
    assign req_tag   = req_q.addr[ADDR_WIDTH-1 -: TAG_W];

    assign hit           = line_valid && (line_tag == look_tag);
    assign cpu_req_ready = (state_q == ST_IDLE) && !inv_all;
    assign accept        = cpu_req_valid && cpu_req_ready;

    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign l2_req_valid  = l2_valid_q && !l2_rsp_valid;
    assign l2_req_addr   = l2_addr_q;
    assign l2_req_we     = l2_we_q;
    assign l2_req_wdata  = l2_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        inv_pend_d  = inv_pend_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        l2_valid_d  = l2_valid_q;
        l2_addr_d   = l2_addr_q;
        l2_we_d     = l2_we_q;
        l2_wdata_d  = l2_wdata_q;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_off      = cnt_q;
        wr_data     = l2_rsp_rdata;
        tag_we      = 1'b0;
        valid_wdata = 1'b0;
        clr_all     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inv_all) begin
                    clr_all = 1'b1;
                end else if (accept) begin
                    req_d = '{addr: cpu_req_addr, we: cpu_req_we, wdata: cpu_req_wdata};
                    cnt_d = '0;
                    if (cpu_req_we) begin
                        if (hit) begin
                            wr_en   = 1'b1;
                            wr_idx  = look_idx;
                            wr_off  = look_off;
                            wr_data = cpu_req_wdata;
                        end
`ifdef L1D_WRITE_ALLOCATE_EN
                        if (!hit) begin
                            state_d    = ST_REFILL;
                            l2_valid_d = 1'b1;
                            l2_we_d    = 1'b0;
                            l2_addr_d  = {cpu_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            l2_wdata_d = '0;
                        end else begin
                            state_d    = ST_WRITE_THRU;
                            l2_valid_d = 1'b1;
                            l2_we_d    = 1'b1;
                            l2_addr_d  = cpu_req_addr;
                            l2_wdata_d = cpu_req_wdata;
                        end
`else
                        state_d    = ST_WRITE_THRU;
                        l2_valid_d = 1'b1;
                        l2_we_d    = 1'b1;
                        l2_addr_d  = cpu_req_addr;
                        l2_wdata_d = cpu_req_wdata;
`endif
                    end else if (hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = line_word;
                    end else begin
                        state_d    = ST_REFILL;
                        l2_valid_d = 1'b1;
                        l2_we_d    = 1'b0;
                        l2_addr_d  = {cpu_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        l2_wdata_d = '0;
                    end
                end
            end

            ST_REFILL: begin
                if (inv_all)
                    inv_pend_d = 1'b1;
                if (l2_rsp_valid) begin
                    wr_en = 1'b1;
                    // an allocating store merges its word as the line streams in
                    if (req_q.we && (cnt_q == req_off))
                        wr_data = req_q.wdata;
                    if (cnt_q == LAST_WORD) begin
                        tag_we      = 1'b1;
                        valid_wdata = !(inv_pend_q || inv_all);
                        cnt_d       = '0;
                        if (req_q.we) begin
                            state_d    = ST_WRITE_THRU;
                            l2_we_d    = 1'b1;
                            l2_addr_d  = req_q.addr;
                            l2_wdata_d = req_q.wdata;
                        end else begin
                            state_d    = ST_RESPOND;
                            l2_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        l2_addr_d = {req_q.addr[ADDR_WIDTH-1:OFF_W], cnt_d};
                    end
                end
            end

            ST_WRITE_THRU: begin
                if (inv_all)
                    inv_pend_d = 1'b1;
                if (l2_rsp_valid) begin
                    l2_valid_d = 1'b0;
                    state_d    = ST_RESPOND;
                end
            end

            ST_RESPOND: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = req_q.we ? '0 : line_word;
                state_d     = ST_IDLE;
                // deferred invalidate lands on the edge that re-enters IDLE
                if (inv_pend_q || inv_all) begin
                    clr_all    = 1'b1;
                    inv_pend_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            inv_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            l2_valid_q  <= 1'b0;
            l2_addr_q   <= '0;
            l2_we_q     <= 1'b0;
            l2_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            inv_pend_q  <= inv_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            l2_valid_q  <= l2_valid_d;
            l2_addr_q   <= l2_addr_d;
            l2_we_q     <= l2_we_d;
            l2_wdata_q  <= l2_wdata_d;
        end
    end

    l1d_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (look_idx),
        .rd_off      (look_off),
        .rd_valid    (line_valid),
        .rd_tag      (line_tag),
        .rd_word     (line_word),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_off      (wr_off),
        .wr_data     (wr_data),
        .tag_we      (tag_we),
        .tag_idx     (req_idx),
        .tag_wdata   (req_tag),
        .valid_wdata (valid_wdata),
        .clr_all     (clr_all)
    );

endmodule

// File: tb/tb_l1_dcache.sv
// Directed plus randomized bench for l1_dcache against a line-level cache
// model and an L2 memory model with configurable response delay.
module tb_l1_dcache;

    localparam int NL = 64;
    localparam int LW = 4;

    logic        clk, rst_n, inv_all;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        l2_req_valid, l2_req_we;
    logic [31:0] l2_req_addr, l2_req_wdata;
    logic        l2_rsp_valid;
    logic [31:0] l2_rsp_rdata;

    l1_dcache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inv_all       (inv_all),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .l2_req_valid  (l2_req_valid),
        .l2_req_addr   (l2_req_addr),
        .l2_req_we     (l2_req_we),
        .l2_req_wdata  (l2_req_wdata),
        .l2_rsp_valid  (l2_rsp_valid),
        .l2_rsp_rdata  (l2_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // L2 memory: untouched words read as addr+0x60, stores overwrite
    logic [31:0] mem_wr [int unsigned];
    function automatic logic [31:0] l2_read(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return a + 32'h60;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } l2_txn_t;

    l2_txn_t l2_log[$];
    int dly = 1;
    int last_rsp_cyc = 0;

    initial begin
        int cnt;
        l2_txn_t t;
        cnt = 0;
        l2_rsp_valid = 1'b0;
        l2_rsp_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (l2_rsp_valid) begin
                l2_rsp_valid = 1'b0;
                cnt = 0;
            end
            #1;
            if (l2_req_valid && rst_n) begin
                if (cnt >= dly) begin
                    t.addr  = l2_req_addr;
                    t.we    = l2_req_we;
                    t.wdata = l2_req_wdata;
                    l2_log.push_back(t);
                    if (l2_req_we) mem_wr[l2_req_addr] = l2_req_wdata;
                    else           l2_rsp_rdata = l2_read(l2_req_addr);
                    l2_rsp_valid = 1'b1;
                    last_rsp_cyc = cyc;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // handshake monitor: no request during a response, request held stable
    int overlap_cnt = 0;
    int unstable_cnt = 0;
    logic        prev_v = 1'b0;
    logic [64:0] prev_req = '0;
    always @(negedge clk) begin
        if (l2_req_valid && l2_rsp_valid) overlap_cnt++;
        if (prev_v && l2_req_valid && (prev_req != {l2_req_addr, l2_req_we, l2_req_wdata}))
            unstable_cnt++;
        prev_v   = l2_req_valid;
        prev_req = {l2_req_addr, l2_req_we, l2_req_wdata};
    end

    // reference cache: which line tags are resident
    bit          mv [NL];
    logic [31:0] mt [NL];

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / LW) % NL);
    endfunction
    function automatic logic [31:0] m_tag(input logic [31:0] a);
        return a / (LW * NL);
    endfunction
    function automatic bit m_hit(input logic [31:0] a);
        return mv[m_idx(a)] && (mt[m_idx(a)] == m_tag(a));
    endfunction
    task automatic model_clear();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ":ready"},    32'(cpu_req_ready), 32'd1);
        chk({nm, ":rsp_v"},    32'(cpu_rsp_valid), 32'd0);
        chk({nm, ":rsp_d"},    cpu_rsp_rdata,      32'd0);
        chk({nm, ":l2_v"},     32'(l2_req_valid),  32'd0);
        chk({nm, ":l2_addr"},  l2_req_addr,        32'd0);
        chk({nm, ":l2_we"},    32'(l2_req_we),     32'd0);
        chk({nm, ":l2_wdata"}, l2_req_wdata,       32'd0);
    endtask

    task automatic do_req(input logic [31:0] a, input bit we, input logic [31:0] wd,
                          input bit inv_same, input string nm);
        bit          hit, got, alloc, fills;
        int          acc_cyc, rsp_cyc;
        logic [31:0] rd_seen, exp_rd, base;
        logic [31:0] ea[$];
        bit          ew[$];
        logic [31:0] ed[$];
`ifdef L1D_WRITE_ALLOCATE_EN
        alloc = 1'b1;
`else
        alloc = 1'b0;
`endif
        acc_cyc = 0;
        rsp_cyc = 0;
        rd_seen = '0;
        @(posedge clk);
        #1;
        l2_log.delete();
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_we    = we;
        cpu_req_wdata = wd;
        if (inv_same) begin
            inv_all = 1'b1;
            @(negedge clk);
            chk({nm, ":ready_during_inv"}, 32'(cpu_req_ready), 32'd0);
            @(posedge clk);
            #1;
            inv_all = 1'b0;
            model_clear();
        end
        hit   = m_hit(a);
        base  = a - (a % LW);
        fills = !hit && (!we || alloc);
        if (fills)
            for (int k = 0; k < LW; k++) begin
                ea.push_back(base + 32'(k)); ew.push_back(1'b0); ed.push_back(32'd0);
            end
        if (we) begin
            ea.push_back(a); ew.push_back(1'b1); ed.push_back(wd);
        end
        exp_rd = we ? 32'd0 : l2_read(a);

        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cpu_req_ready) begin got = 1'b1; acc_cyc = cyc; end
        end
        chk({nm, ":accepted"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (cpu_rsp_valid) begin got = 1'b1; rsp_cyc = cyc; rd_seen = cpu_rsp_rdata; end
        end
        chk({nm, ":rsp_seen"}, 32'(got), 32'd1);
        chk({nm, ":rdata"}, rd_seen, exp_rd);
        @(negedge clk);
        chk({nm, ":rsp_one_cycle"}, 32'(cpu_rsp_valid), 32'd0);

        if (!we && hit)
            chk({nm, ":hit_latency"}, 32'(rsp_cyc - acc_cyc), 32'd1);
        else
            chk({nm, ":l2_to_rsp_latency"}, 32'(rsp_cyc - last_rsp_cyc), 32'd2);
        if (!we && !hit && dly == 1)
            chk({nm, ":miss_latency"}, 32'(rsp_cyc - acc_cyc), 32'(2 + 2 * LW));

        chk({nm, ":l2_count"}, 32'(l2_log.size()), 32'(ea.size()));
        for (int k = 0; k < ea.size() && k < l2_log.size(); k++) begin
            chk({nm, ":l2_addr"}, l2_log[k].addr, ea[k]);
            chk({nm, ":l2_we"}, 32'(l2_log[k].we), 32'(ew[k]));
            if (ew[k]) chk({nm, ":l2_wdata"}, l2_log[k].wdata, ed[k]);
        end

        if (fills) begin
            mv[m_idx(a)] = 1'b1;
            mt[m_idx(a)] = m_tag(a);
        end
    endtask

    logic [31:0] bases [5] = '{32'h40, 32'h140, 32'h80, 32'h180, 32'h240};

    initial begin
        bit got;
        rst_n         = 1'b0;
        inv_all       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_we    = 1'b0;
        cpu_req_wdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;

        dly = 1;
        do_req(32'h40, 1'b0, 32'h0, 1'b0, "cold_rd_40");
        do_req(32'h42, 1'b0, 32'h0, 1'b0, "hit_rd_42");
        do_req(32'h41, 1'b1, 32'hDEAD, 1'b0, "st_hit_41");
        do_req(32'h41, 1'b0, 32'h0, 1'b0, "rd_41_after_st");
        do_req(32'h40 + NL * LW, 1'b0, 32'h0, 1'b0, "conflict_rd");
        do_req(32'h40, 1'b0, 32'h0, 1'b0, "reread_40");
        do_req(32'h80, 1'b1, 32'h1234_5678, 1'b0, "st_miss_80");
        do_req(32'h80, 1'b0, 32'h0, 1'b0, "rd_80_after_st");

        do_req(32'h140, 1'b0, 32'h0, 1'b0, "evict_40");
        fork
            begin
                repeat (4) @(posedge clk);
                #1 inv_all = 1'b1;
                @(posedge clk);
                #1 inv_all = 1'b0;
            end
        join_none
        do_req(32'h40, 1'b0, 32'h0, 1'b0, "inv_in_refill");
        model_clear();
        do_req(32'h40, 1'b0, 32'h0, 1'b0, "rd_after_inv");
        do_req(32'h43, 1'b0, 32'h0, 1'b1, "inv_with_req");

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a   = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 3));
            dly = int'($urandom_range(1, 3));
            do_req(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) == 0), "rnd");
        end

        dly = 1;
        @(posedge clk);
        #1 inv_all = 1'b1;
        @(posedge clk);
        #1 inv_all = 1'b0;
        model_clear();
        l2_log.delete();
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h40;
        cpu_req_we    = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (l2_log.size() == 1 && l2_req_valid) got = 1'b1;
        end
        chk("rst_mid:second_word_reached", 32'(got), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(32'h40, 1'b0, 32'h0, 1'b0, "rd_after_rst");

        chk("no_req_during_rsp", 32'(overlap_cnt), 32'd0);
        chk("l2_req_stable", 32'(unstable_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
